// File: rtl/sync_and_filter.sv
// Input conditioner: multi-flop synchronizer feeding a saturating
// up/down integrator with hysteresis thresholds on the output level.
module sync_and_filter #(
   parameter int unsigned CTR_WIDTH   = 4,
   parameter int unsigned HIGH_THRESH = 12,
   parameter int unsigned LOW_THRESH  = 3,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic clean_out_o
);

   localparam int unsigned CTR_MAX = (1 << CTR_WIDTH) - 1;

   localparam logic [CTR_WIDTH-1:0] HI_T = CTR_WIDTH'(HIGH_THRESH);
   localparam logic [CTR_WIDTH-1:0] LO_T = CTR_WIDTH'(LOW_THRESH);
   localparam logic [CTR_WIDTH-1:0] MAX_T = '1;

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("sync_and_filter: SYNC_STAGES must be >= 2");
   end
   if (LOW_THRESH >= HIGH_THRESH) begin : g_bad_order
      $error("sync_and_filter: LOW_THRESH must be < HIGH_THRESH");
   end
   if (HIGH_THRESH > CTR_MAX) begin : g_bad_high
      $error("sync_and_filter: HIGH_THRESH exceeds counter range");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic [CTR_WIDTH-1:0]   ctr_q;
   logic [CTR_WIDTH-1:0]   ctr_d;
   logic                   clean_q;
   logic                   clean_d;

   assign sync        = sync_q[SYNC_STAGES-1];
   assign clean_out_o = clean_q;

   // Pure flop chain; stage 0 is the metastability catcher.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      end
   end

   always_comb begin
      ctr_d   = ctr_q;
      clean_d = clean_q;
      if (sync && (ctr_q != MAX_T)) begin
         ctr_d = ctr_q + 1'b1;
      end else if (!sync && (ctr_q != '0)) begin
         ctr_d = ctr_q - 1'b1;
      end
      // Between the thresholds the output keeps its last level.
      if (ctr_d >= HI_T) begin
         clean_d = 1'b1;
      end else if (ctr_d <= LO_T) begin
         clean_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctr_q   <= '0;
         clean_q <= 1'b0;
      end else begin
         ctr_q   <= ctr_d;
         clean_q <= clean_d;
      end
   end

endmodule

// File: tb/tb_sync_and_filter.sv
// Directed bench for sync_and_filter with hand-computed expectations.
module tb_sync_and_filter;

   logic clk_i;
   logic rst_i;
   logic async_i;
   logic clean_out_o;

   int n_chk;
   int n_err;

   sync_and_filter dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .async_i    (async_i),
      .clean_out_o(clean_out_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // async value per cycle and expected ctr after each edge
   logic       g_in [16] = '{1,0,1,0,1,0,1,1,0,0,1,1,0,0,0,0};
   logic [3:0] g_ct [16] = '{0,0,1,0,1,0,1,0,1,2,1,0,1,2,1,0};

   initial begin
      n_chk   = 0;
      n_err   = 0;
      rst_i   = 1'b0;
      async_i = 1'b0;

      // reset asserted before any clock edge
      #2 rst_i = 1'b1;
      #1;
      chk("rst_clean", clean_out_o, 0);
      chk("rst_ctr", dut.ctr_q, 0);
      chk("rst_sync", dut.sync_q, 0);
      step();
      step();
      rst_i   = 1'b0;
      async_i = 1'b1;

      // rise: low through edge 13, high on 14
      for (int k = 1; k <= 13; k++) begin
         step();
         chk($sformatf("rise_low_e%0d", k), clean_out_o, 0);
         if (k == 3) chk("rise_ctr_e3", dut.ctr_q, 1);
      end
      step();
      chk("rise_e14", clean_out_o, 1);
      chk("rise_ctr_e14", dut.ctr_q, 12);
      repeat (30) step();
      chk("sat_ctr", dut.ctr_q, 15);
      chk("sat_clean", clean_out_o, 1);

      // fall: high through edge 13, low on 14
      async_i = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         step();
         chk($sformatf("fall_high_e%0d", k), clean_out_o, 1);
      end
      chk("fall_ctr_e13", dut.ctr_q, 4);
      step();
      chk("fall_e14", clean_out_o, 0);
      chk("fall_ctr_e14", dut.ctr_q, 3);
      repeat (20) step();
      chk("floor_ctr", dut.ctr_q, 0);
      chk("floor_clean", clean_out_o, 0);

      // glitch trains
      for (int k = 0; k < 16; k++) begin
         async_i = g_in[k];
         step();
         chk($sformatf("glitch_ctr_%0d", k), dut.ctr_q, g_ct[k]);
         chk($sformatf("glitch_out_%0d", k), clean_out_o, 0);
      end

      // hysteresis: peak of 11 never sets output
      for (int k = 1; k <= 16; k++) begin
         async_i = (k <= 11);
         step();
         chk($sformatf("hys_up_out_%0d", k), clean_out_o, 0);
         if (k == 13) chk("hys_peak", dut.ctr_q, 11);
         if (k == 14) chk("hys_after", dut.ctr_q, 10);
      end
      async_i = 1'b0;
      repeat (20) step();
      chk("hys_floor", dut.ctr_q, 0);

      // charge to 15, then dip to 4 and come back
      async_i = 1'b1;
      repeat (20) step();
      chk("hys_full_ctr", dut.ctr_q, 15);
      chk("hys_full_out", clean_out_o, 1);
      for (int k = 1; k <= 24; k++) begin
         async_i = (k >= 12);
         step();
         chk($sformatf("hys_dn_out_%0d", k), clean_out_o, 1);
         if (k == 13) chk("hys_min", dut.ctr_q, 4);
         if (k == 14) chk("hys_turn", dut.ctr_q, 5);
      end
      chk("hys_refill", dut.ctr_q, 15);

      // drain, then charge to 8
      async_i = 1'b0;
      repeat (17) step();
      chk("mid_drain", dut.ctr_q, 0);
      async_i = 1'b1;
      repeat (10) step();
      chk("mid_ctr8", dut.ctr_q, 8);
      chk("mid_out8", clean_out_o, 0);

      // half-period reset pulse between edges
      rst_i = 1'b1;
      #1;
      chk("mid_rst_ctr", dut.ctr_q, 0);
      chk("mid_rst_out", clean_out_o, 0);
      chk("mid_rst_sync", dut.sync_q, 0);
      #4 rst_i = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         step();
         chk($sformatf("mid_low_e%0d", k), clean_out_o, 0);
      end
      step();
      chk("mid_rise_e14", clean_out_o, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
